// File: rtl/vga_box_overlay_driver.sv
// VGA timing generator with up to N_BOX solid square sprites over a background colour.
// Box state is shadowed at the last pixel of each frame; every output is registered with one cycle of latency.
module vga_box_overlay_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int N_BOX    = 4,
    parameter int BOX_SIZE = 16,
    parameter int COLOR_W  = 4,
    parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                           I_clk,
    input  logic                           I_rst_n,
    input  logic [10*N_BOX-1:0]            I_box_x,
    input  logic [10*N_BOX-1:0]            I_box_y,
    input  logic [N_BOX-1:0]               I_box_en,
    input  logic [3*COLOR_W*N_BOX-1:0]     I_box_color,
    output logic [COLOR_W-1:0]             O_red,
    output logic [COLOR_W-1:0]             O_green,
    output logic [COLOR_W-1:0]             O_blue,
    output logic                           O_hs,
    output logic                           O_vs,
    output logic                           O_de,
    output logic [9:0]                     O_x,
    output logic [9:0]                     O_y,
    output logic                           O_frame_start
);

    localparam int CW      = 3 * COLOR_W;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
    localparam logic [10:0] H_LAST_L = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST_L = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_BEG_L = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_L = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG_L = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_L = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BOX_L    = 11'(BOX_SIZE);
    localparam logic        HS_ACT   = 1'(HS_POL);
    localparam logic        VS_ACT   = 1'(VS_POL);

    // Evaluated 11 bits wide so a box near coordinate 1023 runs off the edge instead of wrapping.
    function automatic logic box_hit(input logic en, input logic [9:0] bx, input logic [9:0] by,
                                     input logic [10:0] x, input logic [10:0] y);
        logic [10:0] x0;
        logic [10:0] y0;
        x0 = {1'b0, bx};
        y0 = {1'b0, by};
        return en && (x >= x0) && (x < x0 + BOX_L) && (y >= y0) && (y < y0 + BOX_L);
    endfunction

    logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        line_end, frame_end;

    logic [10*N_BOX-1:0] sh_x_q, sh_y_q;
    logic [N_BOX-1:0]    sh_en_q;
    logic [CW*N_BOX-1:0] sh_color_q;

    logic               active, hs_on, vs_on;
    logic [CW-1:0]      pix;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [9:0]         x_q, x_d, y_q, y_d;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST_L);
        frame_end = line_end && (v_cnt_q == V_LAST_L);
        h_cnt_d   = line_end ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d   = v_cnt_q;
        if (line_end) begin
            v_cnt_d = (v_cnt_q == V_LAST_L) ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        active = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
        hs_on  = (h_cnt_q >= HS_BEG_L) && (h_cnt_q < HS_END_L);
        vs_on  = (v_cnt_q >= VS_BEG_L) && (v_cnt_q < VS_END_L);
        pix    = BG_COLOR;
        // Scan from the highest index down so the lowest hitting box is the last assignment.
        for (int i = N_BOX - 1; i >= 0; i--) begin
            if (box_hit(sh_en_q[i], sh_x_q[10*i +: 10], sh_y_q[10*i +: 10], h_cnt_q, v_cnt_q)) begin
                pix = sh_color_q[CW*i +: CW];
            end
        end
    end

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        x_d     = x_q;
        y_d     = y_q;
        if (active) begin
            red_d   = pix[CW-1 -: COLOR_W];
            green_d = pix[2*COLOR_W-1 -: COLOR_W];
            blue_d  = pix[COLOR_W-1:0];
            x_d     = h_cnt_q[9:0];
            y_d     = v_cnt_q[9:0];
        end
        de_d = active;
        hs_d = hs_on ? HS_ACT : ~HS_ACT;
        vs_d = vs_on ? VS_ACT : ~VS_ACT;
        fs_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_en_q    <= '0;
            sh_color_q <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hs_q       <= ~HS_ACT;
            vs_q       <= ~VS_ACT;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            fs_q       <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (frame_end) begin
                sh_x_q     <= I_box_x;
                sh_y_q     <= I_box_y;
                sh_en_q    <= I_box_en;
                sh_color_q <= I_box_color;
            end
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
        end
    end

    assign O_red         = red_q;
    assign O_green       = green_q;
    assign O_blue        = blue_q;
    assign O_hs          = hs_q;
    assign O_vs          = vs_q;
    assign O_de          = de_q;
    assign O_x           = x_q;
    assign O_y           = y_q;
    assign O_frame_start = fs_q;

endmodule

// File: tb/tb_vga_box_overlay_driver.sv
// Scoreboard bench for vga_box_overlay_driver on a reduced 14x8 timing: a pixel-time reference model
// predicts every output cycle, a monitor pops and compares one expectation per clock.
module tb_vga_box_overlay_driver;

    localparam int HA = 8, HF = 2, HSY = 3, HB = 1;
    localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int NB = 4;
    localparam int BS = 2;
    localparam logic [11:0] BG = 12'h00A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] box_x, box_y;
    logic [3:0]  box_en;
    logic [47:0] box_color;
    logic [3:0]  red, green, blue;
    logic        hs, vs, de, fs;
    logic [9:0]  ox, oy;

    always #5 clk = ~clk;

    vga_box_overlay_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .N_BOX(NB), .BOX_SIZE(BS),
        .COLOR_W(4), .BG_COLOR(BG)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_box_x(box_x), .I_box_y(box_y), .I_box_en(box_en), .I_box_color(box_color),
        .O_red(red), .O_green(green), .O_blue(blue),
        .O_hs(hs), .O_vs(vs), .O_de(de), .O_x(ox), .O_y(oy), .O_frame_start(fs)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    int          last_x = 0, last_y = 0;
    int          sh_x[NB], sh_y[NB];
    bit          sh_en[NB];
    logic [11:0] sh_c[NB];

    // Reference: pixel position is (t mod HT, t div HT mod VT); box state seen by a frame is
    // whatever was on the inputs during the final clock of the previous frame.
    task automatic step();
        exp_t e;
        int   h, v;
        bit   act, found;
        if (!rst_n) begin
            e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
            e.x = 10'd0; e.y = 10'd0; e.fs = 1'b0;
            t = 0; last_x = 0; last_y = 0;
            for (int i = 0; i < NB; i++) begin
                sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; sh_c[i] = 12'h000;
            end
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            act = (h < HA) && (v < VA);
            if (act) begin
                last_x = h;
                last_y = v;
            end
            e.rgb = 12'h000;
            if (act) begin
                e.rgb = BG;
                found = 0;
                for (int i = 0; i < NB; i++) begin
                    if (!found && sh_en[i] && h >= sh_x[i] && h < sh_x[i] + BS &&
                        v >= sh_y[i] && v < sh_y[i] + BS) begin
                        e.rgb = sh_c[i];
                        found = 1;
                    end
                end
            end
            e.hs = (h >= HA + HF && h < HA + HF + HSY) ? 1'b0 : 1'b1;
            e.vs = (v >= VA + VF && v < VA + VF + VSY) ? 1'b0 : 1'b1;
            e.de = act;
            e.x  = 10'(last_x);
            e.y  = 10'(last_y);
            e.fs = (h == 0) && (v == 0);
            if (h == HT - 1 && v == VT - 1) begin
                for (int i = 0; i < NB; i++) begin
                    sh_x[i]  = int'(box_x[10*i +: 10]);
                    sh_y[i]  = int'(box_y[10*i +: 10]);
                    sh_en[i] = box_en[i];
                    sh_c[i]  = box_color[12*i +: 12];
                end
            end
            t++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to_phase(input int ph);
        while (t % FRAME != ph) step();
    endtask

    task automatic set_box(input int i, input int x, input int y, input bit en, input logic [11:0] c);
        box_x[10*i +: 10]     = 10'(x);
        box_y[10*i +: 10]     = 10'(y);
        box_en[i]             = en;
        box_color[12*i +: 12] = c;
    endtask

    function automatic int rand_coord();
        case ($urandom_range(0, 5))
            0:       return 1023;
            1:       return 1022;
            default: return int'($urandom_range(0, 9));
        endcase
    endfunction

    initial begin : monitor
        exp_t e, a;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.rgb = {red, green, blue}; a.hs = hs; a.vs = vs; a.de = de;
                a.x = ox; a.y = oy; a.fs = fs;
                checks++;
                if (a !== e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL pixel#%0d: got rgb=%h hs=%b vs=%b de=%b x=%0d y=%0d fs=%b, want rgb=%h hs=%b vs=%b de=%b x=%0d y=%0d fs=%b",
                                 n, a.rgb, a.hs, a.vs, a.de, a.x, a.y, a.fs,
                                 e.rgb, e.hs, e.vs, e.de, e.x, e.y, e.fs);
                end
                n++;
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        box_x = '0; box_y = '0; box_en = '0; box_color = '0;
        @(negedge clk);
        run(5);
        rst_n = 1'b1;

        set_box(0, 3, 1, 1'b1, 12'hF00);
        run(2 * FRAME);

        set_box(0, 2, 2, 1'b1, 12'h0F0);
        set_box(1, 3, 2, 1'b1, 12'h00F);
        run(2 * FRAME);
        set_box(0, 2, 2, 1'b0, 12'h0F0);
        run(2 * FRAME);

        run_to_phase(50);
        set_box(1, 5, 1, 1'b1, 12'h00F);
        run(2 * FRAME);

        set_box(0, 1023, 0, 1'b1, 12'hF00);
        set_box(1, 0, 1023, 1'b1, 12'h0F0);
        set_box(2, 1022, 1023, 1'b1, 12'hFF0);
        set_box(3, 7, 3, 1'b1, 12'h0FF);
        run(2 * FRAME);

        run_to_phase(60);
        rst_n = 1'b0;
        run(5);
        rst_n = 1'b1;
        run(2 * FRAME);

        repeat (30 * FRAME) begin
            if ($urandom_range(0, 19) == 0)
                set_box(int'($urandom_range(0, NB - 1)), rand_coord(), rand_coord(),
                        bit'($urandom_range(0, 3) != 0), 12'($urandom));
            step();
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
